// File: rtl/cube_color_tracker.sv
// Pyramid cube colour tracker: applies Q*bert landings to per-cube colour bits,
// counts coloured cubes, flags a level win and exposes state over Avalon-MM.
module cube_color_tracker #(
  parameter int unsigned N_CUBE = 28,
  parameter int unsigned IDX_W  = 5
) (
  input  logic              CLK_33,
  input  logic              reset,
  input  logic              done_move,
  input  logic [N_CUBE-1:0] position_qb,
  input  logic              e_start_qb,
  input  logic              e_pause_qb,
  input  logic [1:0]        avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic [N_CUBE-1:0] color_state,
  output logic [IDX_W-1:0]  colored_count,
  output logic              land_valid,
  output logic [IDX_W-1:0]  land_index,
  output logic              win_pulse,
  output logic              win_flag
);

  typedef enum logic [1:0] {StIdle, StDecode, StUpdate, StWon} state_e;

  state_e              r_state, w_state_d;
  logic                r_done_d;
  logic [N_CUBE-1:0]   r_pos;
  logic [IDX_W-1:0]    r_idx;
  logic [N_CUBE-1:0]   r_color;
  logic [IDX_W-1:0]    r_count;
  logic                r_land_valid;
  logic [IDX_W-1:0]    r_land_index;
  logic                r_win_pulse;
  logic                r_win_flag;
  logic                r_overrun;
  logic                r_invalid;
  logic                r_toggle;
  logic [15:0]         r_landings;
  logic [31:0]         r_readdata;

  logic                w_edge;
  logic                w_accept;
  logic                w_wr_color;
  logic                w_wr_status;
  logic                w_wr_ctrl;
  logic                w_clear;
  logic                w_color_drop;
  logic                w_win;
  logic                w_onehot;
  logic [IDX_W-1:0]    w_idx;
  logic [IDX_W-1:0]    w_popcnt;
  logic [31:0]         w_status;
  logic                w_unused;

  assign w_edge       = done_move & ~r_done_d;
  assign w_accept     = (r_state == StIdle) & w_edge & ~e_pause_qb;
  assign w_wr_color   = avs_write & (avs_address == 2'd0);
  assign w_wr_status  = avs_write & (avs_address == 2'd1);
  assign w_wr_ctrl    = avs_write & (avs_address == 2'd2);
  assign w_clear      = e_start_qb | (w_wr_ctrl & avs_writedata[1]);
  assign w_color_drop = w_wr_color & ~(&avs_writedata[N_CUBE-1:0]);
  assign w_onehot     = $onehot(r_pos);
  assign w_unused     = ^avs_writedata[31:N_CUBE];

  // The count lags the colour vector by a cycle, so also require the live vector to be
  // full; otherwise the stale count right after a clear or COLOR write would re-trigger.
  assign w_win = (r_count == IDX_W'(N_CUBE)) & ~r_win_flag & ~w_clear & ~w_color_drop &
                 (&r_color);

  always_comb begin
    w_idx    = '0;
    w_popcnt = '0;
    for (int i = 0; i < N_CUBE; i++) begin
      if (r_pos[i]) w_idx = IDX_W'(i);
      w_popcnt = w_popcnt + IDX_W'(r_color[i]);
    end
  end

  always_comb begin
    w_status             = '0;
    w_status[IDX_W-1:0]  = r_count;
    w_status[8]          = r_win_flag;
    w_status[9]          = r_overrun;
    w_status[10]         = r_invalid;
  end

  always_ff @(posedge CLK_33 or negedge reset) begin
    if (!reset) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (w_accept) w_state_d = StDecode;
      StDecode: w_state_d = w_onehot ? StUpdate : StIdle;
      StUpdate: w_state_d = StIdle;
      StWon:    if (w_color_drop) w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
    if (w_win)   w_state_d = StWon;
    if (w_clear) w_state_d = StIdle;
  end

  always_ff @(posedge CLK_33 or negedge reset) begin
    if (!reset) begin
      r_done_d     <= 1'b0;
      r_pos        <= '0;
      r_idx        <= '0;
      r_color      <= '0;
      r_count      <= '0;
      r_land_valid <= 1'b0;
      r_land_index <= '0;
      r_win_pulse  <= 1'b0;
      r_win_flag   <= 1'b0;
      r_overrun    <= 1'b0;
      r_invalid    <= 1'b0;
      r_toggle     <= 1'b0;
      r_landings   <= '0;
      r_readdata   <= '0;
    end else begin
      r_done_d     <= done_move;
      r_count      <= w_popcnt;
      r_land_valid <= (r_state == StUpdate);
      r_win_pulse  <= w_win;

      if (w_accept)            r_pos <= position_qb;
      if (r_state == StDecode) r_idx <= w_idx;

      // A COLOR write overrides the colour change of a simultaneous landing.
      if (w_clear)                   r_color <= '0;
      else if (w_wr_color)           r_color <= avs_writedata[N_CUBE-1:0];
      else if (r_state == StUpdate)  r_color[r_idx] <= r_toggle ? ~r_color[r_idx] : 1'b1;

      if (r_state == StUpdate) r_land_index <= r_idx;

      if (w_clear)
        r_landings <= '0;
      else if (r_state == StUpdate && r_landings != 16'hFFFF)
        r_landings <= r_landings + 16'd1;

      if (w_clear)                                r_win_flag <= 1'b0;
      else if (w_win)                             r_win_flag <= 1'b1;
      else if (r_state == StWon && w_color_drop)  r_win_flag <= 1'b0;

      if (w_clear)                                          r_overrun <= 1'b0;
      else if (w_edge && (r_state == StDecode || r_state == StUpdate)) r_overrun <= 1'b1;
      else if (w_wr_status && avs_writedata[9])             r_overrun <= 1'b0;

      if (w_clear)                                r_invalid <= 1'b0;
      else if (r_state == StDecode && !w_onehot)  r_invalid <= 1'b1;
      else if (w_wr_status && avs_writedata[10])  r_invalid <= 1'b0;

      if (w_wr_ctrl) r_toggle <= avs_writedata[0];

      if (avs_read) begin
        case (avs_address)
          2'd0:    r_readdata <= {{(32-N_CUBE){1'b0}}, r_color};
          2'd1:    r_readdata <= w_status;
          2'd2:    r_readdata <= {31'd0, r_toggle};
          default: r_readdata <= {16'd0, r_landings};
        endcase
      end
    end
  end

  assign avs_readdata  = r_readdata;
  assign color_state   = r_color;
  assign colored_count = r_count;
  assign land_valid    = r_land_valid;
  assign land_index    = r_land_index;
  assign win_pulse     = r_win_pulse;
  assign win_flag      = r_win_flag;

endmodule

// File: tb/tb_cube_color_tracker.sv
// Directed bench for cube_color_tracker: expected landings, reads and wins are queued
// by the stimulus and consumed by a monitor that watches the DUT outputs.
module tb_cube_color_tracker;

  logic        CLK_33;
  logic        reset;
  logic        done_move;
  logic [27:0] position_qb;
  logic        e_start_qb;
  logic        e_pause_qb;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic [27:0] color_state;
  logic [4:0]  colored_count;
  logic        land_valid;
  logic [4:0]  land_index;
  logic        win_pulse;
  logic        win_flag;

  int n_tests = 0;
  int n_fail  = 0;

  logic [4:0]  q_land_idx[$];
  logic [27:0] q_land_col[$];
  logic [31:0] q_rd[$];
  int          exp_win = 0;
  logic        rd_vld;

  cube_color_tracker #(.N_CUBE(28), .IDX_W(5)) dut (
    .CLK_33        (CLK_33),
    .reset         (reset),
    .done_move     (done_move),
    .position_qb   (position_qb),
    .e_start_qb    (e_start_qb),
    .e_pause_qb    (e_pause_qb),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata),
    .color_state   (color_state),
    .colored_count (colored_count),
    .land_valid    (land_valid),
    .land_index    (land_index),
    .win_pulse     (win_pulse),
    .win_flag      (win_flag)
  );

  initial CLK_33 = 1'b0;
  always #5 CLK_33 = ~CLK_33;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK_33);
    #1;
  endtask

  always @(posedge CLK_33 or negedge reset) begin
    if (!reset) rd_vld <= 1'b0;
    else        rd_vld <= avs_read;
  end

  // Monitor: every DUT response is matched against the head of its queue.
  always @(negedge CLK_33) begin
    if (land_valid) begin
      if (q_land_idx.size() == 0) begin
        check("unexpected_land_valid", {27'd0, land_valid}, 32'd0);
      end else begin
        check("land_index", {27'd0, land_index}, {27'd0, q_land_idx.pop_front()});
        check("land_color", {4'd0, color_state}, {4'd0, q_land_col.pop_front()});
      end
    end
    if (rd_vld) begin
      if (q_rd.size() == 0) check("unexpected_read", avs_readdata, 32'hDEAD_BEEF);
      else                  check("readdata", avs_readdata, q_rd.pop_front());
    end
    if (win_pulse) begin
      if (exp_win == 0) begin
        check("unexpected_win_pulse", {31'd0, win_pulse}, 32'd0);
      end else begin
        exp_win--;
        check("win_pulse_flag", {31'd0, win_flag}, 32'd1);
      end
    end
  end

  task automatic rd(input logic [1:0] addr, input logic [31:0] exp);
    q_rd.push_back(exp);
    avs_address = addr;
    avs_read    = 1'b1;
    tick();
    avs_read    = 1'b0;
    tick();
  endtask

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    avs_address   = addr;
    avs_writedata = data;
    avs_write     = 1'b1;
    tick();
    avs_write     = 1'b0;
  endtask

  task automatic start_pulse();
    e_start_qb = 1'b1;
    tick();
    e_start_qb = 1'b0;
  endtask

  // Issues one edge; returns #1 after posedge E+4.
  task automatic land(input logic [27:0] pos, input bit evt, input logic [4:0] idx,
                      input logic [27:0] col);
    if (evt) begin
      q_land_idx.push_back(idx);
      q_land_col.push_back(col);
    end
    position_qb = pos;
    done_move   = 1'b1;
    tick();
    done_move   = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [27:0] mdl;
    logic [27:0] p;
    reset         = 1'b0;
    done_move     = 1'b0;
    position_qb   = '0;
    e_start_qb    = 1'b0;
    e_pause_qb    = 1'b0;
    avs_address   = '0;
    avs_read      = 1'b0;
    avs_write     = 1'b0;
    avs_writedata = '0;
    #12;
    check("rst_color", {4'd0, color_state}, 32'd0);
    check("rst_count", {27'd0, colored_count}, 32'd0);
    check("rst_land_valid", {31'd0, land_valid}, 32'd0);
    check("rst_win_flag", {31'd0, win_flag}, 32'd0);
    check("rst_readdata", avs_readdata, 32'd0);
    reset = 1'b1;
    tick();
    rd(2'd1, 32'h0);
    rd(2'd2, 32'h0);
    rd(2'd3, 32'h0);

    // First landing on cube 0 with cycle-exact timing
    q_land_idx.push_back(5'd0);
    q_land_col.push_back(28'h1);
    position_qb = 28'h1;
    done_move   = 1'b1;
    tick();
    done_move = 1'b0;
    check("t1_color_E", {4'd0, color_state}, 32'd0);
    tick();
    check("t1_color_E1", {4'd0, color_state}, 32'd0);
    tick();
    check("t1_color_E2", {4'd0, color_state}, 32'h1);
    check("t1_count_E2", {27'd0, colored_count}, 32'd0);
    tick();
    check("t1_count_E3", {27'd0, colored_count}, 32'd1);
    check("t1_land_valid_E3", {31'd0, land_valid}, 32'd0);
    tick();
    check("t1_win_flag", {31'd0, win_flag}, 32'd0);
    rd(2'd0, 32'h1);

    // Toggle mode: two landings on cube 27
    start_pulse();
    rd(2'd3, 32'h0);
    wr(2'd2, 32'h1);
    land(28'h8000000, 1'b1, 5'd27, 28'h8000000);
    check("t2_count_one", {27'd0, colored_count}, 32'd1);
    land(28'h8000000, 1'b1, 5'd27, 28'h0);
    rd(2'd3, 32'd2);
    rd(2'd2, 32'h1);
    check("t2_count_zero", {27'd0, colored_count}, 32'd0);

    // Invalid positions: zero and multi-hot
    start_pulse();
    wr(2'd2, 32'h0);
    land(28'h0, 1'b0, 5'd0, 28'h0);
    land(28'h3, 1'b0, 5'd0, 28'h0);
    rd(2'd0, 32'h0);
    rd(2'd1, 32'h400);
    wr(2'd1, 32'h400);
    rd(2'd1, 32'h0);

    // Colour every cube in set mode, the last one wins at E+4
    mdl = '0;
    for (int i = 0; i < 28; i++) begin
      p   = 28'd1 << i;
      mdl = mdl | p;
      if (i == 27) exp_win++;
      land(p, 1'b1, 5'(i), mdl);
    end
    check("t4_win_pulse_E4", {31'd0, win_pulse}, 32'd1);
    check("t4_win_flag", {31'd0, win_flag}, 32'd1);
    tick();
    check("t4_win_pulse_once", {31'd0, win_pulse}, 32'd0);
    rd(2'd1, 32'h11C);
    land(28'h1, 1'b0, 5'd0, 28'h0);
    check("t4_won_color", {4'd0, color_state}, 32'hFFFFFFF);
    rd(2'd3, 32'd28);
    rd(2'd1, 32'h11C);
    start_pulse();
    check("t4_clear_color", {4'd0, color_state}, 32'd0);
    check("t4_clear_win", {31'd0, win_flag}, 32'd0);
    tick();
    check("t4_clear_count", {27'd0, colored_count}, 32'd0);
    land(28'h4, 1'b1, 5'd2, 28'h4);

    // Overrun: second edge lands while the first is in UPDATE
    start_pulse();
    q_land_idx.push_back(5'd0);
    q_land_col.push_back(28'h1);
    position_qb = 28'h1;
    done_move   = 1'b1;
    tick();
    done_move = 1'b0;
    tick();
    position_qb = 28'h2;
    done_move   = 1'b1;
    tick();
    done_move = 1'b0;
    repeat (4) tick();
    check("t5_color", {4'd0, color_state}, 32'h1);
    rd(2'd1, 32'h201);
    wr(2'd1, 32'h200);
    rd(2'd1, 32'h001);
    e_pause_qb = 1'b1;
    land(28'h2, 1'b0, 5'd0, 28'h0);
    e_pause_qb = 1'b0;
    rd(2'd1, 32'h001);
    land(28'h1, 1'b1, 5'd0, 28'h1);
    rd(2'd3, 32'd2);

    // Win by COLOR write, exit by COLOR write, then async reset mid-UPDATE
    start_pulse();
    exp_win++;
    wr(2'd0, 32'hFFFFFFF);
    check("t6_color_full", {4'd0, color_state}, 32'hFFFFFFF);
    check("t6_count_lag", {27'd0, colored_count}, 32'd0);
    tick();
    check("t6_count_28", {27'd0, colored_count}, 32'd28);
    tick();
    check("t6_win_pulse", {31'd0, win_pulse}, 32'd1);
    wr(2'd0, 32'h0);
    check("t6_exit_win_flag", {31'd0, win_flag}, 32'd0);
    repeat (3) tick();
    check("t6_no_rewin", {31'd0, win_flag}, 32'd0);
    check("t6_count_zero", {27'd0, colored_count}, 32'd0);
    land(28'h10, 1'b1, 5'd4, 28'h10);
    wr(2'd2, 32'h1);
    rd(2'd0, 32'h10);
    position_qb = 28'h100;
    done_move   = 1'b1;
    tick();
    done_move = 1'b0;
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("t6_rst_color", {4'd0, color_state}, 32'd0);
    check("t6_rst_count", {27'd0, colored_count}, 32'd0);
    check("t6_rst_land_index", {27'd0, land_index}, 32'd0);
    check("t6_rst_land_valid", {31'd0, land_valid}, 32'd0);
    check("t6_rst_win", {30'd0, win_pulse, win_flag}, 32'd0);
    check("t6_rst_readdata", avs_readdata, 32'd0);
    #3;
    reset = 1'b1;
    tick();
    tick();
    check("t6_after_rst_color", {4'd0, color_state}, 32'd0);
    rd(2'd2, 32'h0);
    rd(2'd3, 32'h0);

    repeat (3) tick();
    check("land_queue_empty", q_land_idx.size(), 32'd0);
    check("read_queue_empty", q_rd.size(), 32'd0);
    check("win_expect_empty", exp_win, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
